pwl_activation_pipe: RTL and testbench

- Multi-lane, multi-mode piecewise-linear activation unit; successor to the single-lane sigmoid stage.
- Sits between the accumulator/bias stage and the next layer's line buffer in the CNN datapath.
- Processes LANES fixed-point values per beat through a 3-stage pipeline with valid/ready backpressure.
- The activation mode is selected at runtime and travels with each beat.

---
 rtl/pwl_act_pkg.sv | 51 +++++
 rtl/pwl_activation_pipe_lane.sv | 153 +++++++++++++++
 rtl/pwl_activation_pipe.sv | 83 ++++++++
 tb/tb_pwl_activation_pipe.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwl_act_pkg.sv
// ---------------------------------------------------------------------------
// pwl_act_pkg
//   Shared types and fixed-point constants for the piecewise-linear
//   activation pipeline.
//
//   act_mode_t      : activation selector that travels with each beat.
//   fx_* functions  : breakpoints/offsets as unsigned fixed-point values for
//                     a given number of fractional bits. Callers truncate
//                     the 64-bit result to their own data width. Requires
//                     frac_bits >= 5 so every constant is exact.
// ---------------------------------------------------------------------------
package pwl_act_pkg;

    typedef enum logic [1:0] {
        ACT_SIGMOID = 2'b00,
        ACT_TANH    = 2'b01,
        ACT_RELU    = 2'b10,
        ACT_BYPASS  = 2'b11
    } act_mode_t;

    // 5.0
    function automatic logic [63:0] fx_five(input int unsigned frac_bits);
        return 64'd5 << frac_bits;
    endfunction

    // 2.375 = 19/8
    function automatic logic [63:0] fx_2p375(input int unsigned frac_bits);
        return 64'd19 << (frac_bits - 3);
    endfunction

    // 1.0
    function automatic logic [63:0] fx_one(input int unsigned frac_bits);
        return 64'd1 << frac_bits;
    endfunction

    // 0.84375 = 27/32
    function automatic logic [63:0] fx_0p84375(input int unsigned frac_bits);
        return 64'd27 << (frac_bits - 5);
    endfunction

    // 0.625 = 5/8
    function automatic logic [63:0] fx_0p625(input int unsigned frac_bits);
        return 64'd5 << (frac_bits - 3);
    endfunction

    // 0.5
    function automatic logic [63:0] fx_0p5(input int unsigned frac_bits);
        return 64'd1 << (frac_bits - 1);
    endfunction

endpackage

// File: rtl/pwl_activation_pipe_lane.sv
// ---------------------------------------------------------------------------
// pwl_act_lane
//   S2/S3 datapath for one lane. S2 forms |x| (with the tanh 2x pre-scale),
//   picks the segment and registers the segment offset plus shifted term.
//   S3 adds them, applies the negative-input reflection and the tanh
//   rescale, and registers the lane output.
//
//   clk, rst_n : clock / asynchronous active-high reset
//   adv        : pipeline advance, shared by all lanes
//   s1_mode    : mode of the beat currently in S1 (feeds S2 logic)
//   s2_mode    : mode of the beat currently in S2 (feeds S3 logic)
//   s1_data    : this lane's S1 value, signed Q(DW-FB).FB
//   y          : registered activated value (S3)
//   sat        : registered saturation flag (S3)
// ---------------------------------------------------------------------------
module pwl_act_lane
    import pwl_act_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  adv,
    input  act_mode_t             s1_mode,
    input  act_mode_t             s2_mode,
    input  logic [DATA_WIDTH-1:0] s1_data,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  sat
);

    localparam logic [DATA_WIDTH-1:0] K_FIVE    = DATA_WIDTH'(fx_five(FRAC_BITS));
    localparam logic [DATA_WIDTH-1:0] K_2P375   = DATA_WIDTH'(fx_2p375(FRAC_BITS));
    localparam logic [DATA_WIDTH-1:0] K_ONE     = DATA_WIDTH'(fx_one(FRAC_BITS));
    localparam logic [DATA_WIDTH-1:0] K_0P84375 = DATA_WIDTH'(fx_0p84375(FRAC_BITS));
    localparam logic [DATA_WIDTH-1:0] K_0P625   = DATA_WIDTH'(fx_0p625(FRAC_BITS));
    localparam logic [DATA_WIDTH-1:0] K_0P5     = DATA_WIDTH'(fx_0p5(FRAC_BITS));
    localparam logic [DATA_WIDTH-1:0] MAX_POS   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_NEG   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH-1:0] x_s;
    logic [DATA_WIDTH-1:0] a;
    logic                  dbl_sat;
    logic                  a_clip;
    logic [DATA_WIDTH-1:0] base_d;
    logic [DATA_WIDTH-1:0] term_d;
    logic                  neg_d;
    logic                  sat_d;

    logic [DATA_WIDTH-1:0] s2_base;
    logic [DATA_WIDTH-1:0] s2_term;
    logic                  s2_neg;
    logic                  s2_sat;

    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] mag;
    logic [DATA_WIDTH-1:0] y_d;

    // S2: scale, abs, segment select.
    // ReLU/bypass reuse the same registers: base=0 and term carries the
    // final value, so S3's adder passes it through unchanged.
    always_comb begin
        x_s     = s1_data;
        dbl_sat = 1'b0;
        a_clip  = 1'b0;
        a       = '0;
        base_d  = '0;
        term_d  = '0;
        neg_d   = 1'b0;
        sat_d   = 1'b0;

        if (s1_mode == ACT_TANH) begin
            // 2x overflows exactly when the two top bits differ
            if (s1_data[DATA_WIDTH-1] != s1_data[DATA_WIDTH-2]) begin
                dbl_sat = 1'b1;
                x_s     = s1_data[DATA_WIDTH-1] ? MIN_NEG : MAX_POS;
            end else begin
                x_s = {s1_data[DATA_WIDTH-2:0], 1'b0};
            end
        end

        if (x_s == MIN_NEG) begin
            a      = MAX_POS;
            a_clip = 1'b1;
        end else if (x_s[DATA_WIDTH-1]) begin
            a = -x_s;
        end else begin
            a = x_s;
        end

        case (s1_mode)
            ACT_SIGMOID, ACT_TANH: begin
                neg_d = x_s[DATA_WIDTH-1];
                sat_d = dbl_sat | a_clip | (a >= K_FIVE);
                if (a >= K_FIVE) begin
                    base_d = K_ONE;
                end else if (a >= K_2P375) begin
                    base_d = K_0P84375;
                    term_d = a >> 5;
                end else if (a >= K_ONE) begin
                    base_d = K_0P625;
                    term_d = a >> 3;
                end else begin
                    base_d = K_0P5;
                    term_d = a >> 2;
                end
            end
            ACT_RELU: begin
                term_d = s1_data[DATA_WIDTH-1] ? '0 : s1_data;
            end
            default: begin
                term_d = s1_data;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            s2_base <= '0;
            s2_term <= '0;
            s2_neg  <= 1'b0;
            s2_sat  <= 1'b0;
        end else if (adv) begin
            s2_base <= base_d;
            s2_term <= term_d;
            s2_neg  <= neg_d;
            s2_sat  <= sat_d;
        end
    end

    // S3: combine. sum never exceeds 1.0 in sigmoid/tanh, so no overflow.
    always_comb begin
        sum = s2_base + s2_term;
        mag = s2_neg ? (K_ONE - sum) : sum;
        case (s2_mode)
            ACT_SIGMOID: y_d = mag;
            // 2*y - 1.0 formed one bit wider, result always fits DATA_WIDTH
            ACT_TANH:    y_d = DATA_WIDTH'({mag, 1'b0} - {1'b0, K_ONE});
            default:     y_d = sum;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            y   <= '0;
            sat <= 1'b0;
        end else if (adv) begin
            y   <= y_d;
            sat <= s2_sat;
        end
    end

endmodule

// File: rtl/pwl_activation_pipe.sv
// ---------------------------------------------------------------------------
// pwl_activation_pipe
//   Multi-lane piecewise-linear activation (sigmoid / tanh / ReLU / bypass),
//   3-stage pipeline with a single global advance for valid/ready flow.
//   S1 registers data and mode here; S2/S3 live in one pwl_act_lane per lane.
//   Parameters must satisfy 5 <= FRAC_BITS <= DATA_WIDTH-4 and LANES >= 1.
//
//   clk      : clock, rising edge
//   rst_n    : asynchronous reset, active-high (1 = reset)
//   i_valid  : input beat valid
//   i_ready  : block accepts a beat this cycle
//   i_mode   : 00 sigmoid, 01 tanh, 10 ReLU, 11 bypass (per beat)
//   i_data   : LANES x DATA_WIDTH, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_valid  : output beat valid
//   o_ready  : downstream accepts the beat
//   o_data   : activated lanes, same packing as i_data
//   o_sat    : per-lane saturation flag
// ---------------------------------------------------------------------------
module pwl_activation_pipe
    import pwl_act_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int LANES      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_valid,
    output logic                        i_ready,
    input  logic [1:0]                  i_mode,
    input  logic [LANES*DATA_WIDTH-1:0] i_data,
    output logic                        o_valid,
    input  logic                        o_ready,
    output logic [LANES*DATA_WIDTH-1:0] o_data,
    output logic [LANES-1:0]            o_sat
);

    logic                        adv;
    logic                        s1_valid;
    logic                        s2_valid;
    act_mode_t                   s1_mode;
    act_mode_t                   s2_mode;
    logic [LANES*DATA_WIDTH-1:0] s1_data;

    // Whole pipe moves together; bubbles shift through rather than collapse.
    assign adv     = !o_valid || o_ready;
    assign i_ready = adv;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            o_valid  <= 1'b0;
            s1_mode  <= ACT_SIGMOID;
            s2_mode  <= ACT_SIGMOID;
            s1_data  <= '0;
        end else if (adv) begin
            s1_valid <= i_valid;
            s2_valid <= s1_valid;
            o_valid  <= s2_valid;
            s1_mode  <= act_mode_t'(i_mode);
            s2_mode  <= s1_mode;
            s1_data  <= i_data;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        pwl_act_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .FRAC_BITS  (FRAC_BITS)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .adv     (adv),
            .s1_mode (s1_mode),
            .s2_mode (s2_mode),
            .s1_data (s1_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .y       (o_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .sat     (o_sat[k])
        );
    end

endmodule

// File: tb/tb_pwl_activation_pipe.sv
// ---------------------------------------------------------------------------
// tb_pwl_activation_pipe
//   Directed and randomized bench for pwl_activation_pipe with a
//   fixed-point reference model and an expected-beat queue.
// ---------------------------------------------------------------------------
module tb_pwl_activation_pipe;

    localparam int DW = 32;
    localparam int FB = 16;
    localparam int LN = 4;
    localparam int W  = LN * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          i_valid;
    logic          i_ready;
    logic [1:0]    i_mode;
    logic [W-1:0]  i_data;
    logic          o_valid;
    logic          o_ready;
    logic [W-1:0]  o_data;
    logic [LN-1:0] o_sat;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [LN-1:0] sat;
    } beat_t;

    beat_t        exp_q[$];
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data;

    pwl_activation_pipe #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (FB),
        .LANES      (LN)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_mode  (i_mode),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_sat   (o_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    // ---------------- reference model (plain fixed-point arithmetic) -------
    function automatic longint sig_pos(input longint a);
        longint one;
        one = longint'(1) <<< FB;
        if (a >= 5 * one)             return one;
        else if (a >= (19 * one) / 8) return (27 * one) / 32 + a / 32;
        else if (a >= one)            return (5 * one) / 8 + a / 8;
        else                          return one / 2 + a / 4;
    endfunction

    function automatic logic [DW:0] model_lane(input logic [1:0] mode, input logic [DW-1:0] raw);
        longint x, xs, a, s, y, one, maxv, minv;
        logic   sat;
        one  = longint'(1) <<< FB;
        maxv = (longint'(1) <<< (DW - 1)) - 1;
        minv = -maxv - 1;
        x    = longint'(signed'(raw));
        sat  = 1'b0;
        y    = 0;
        case (mode)
            2'b10: y = (x < 0) ? 0 : x;
            2'b11: y = x;
            default: begin
                xs = (mode == 2'b01) ? 2 * x : x;
                if (xs > maxv) xs = maxv;
                if (xs < minv) xs = minv;
                a = (xs < 0) ? -xs : xs;
                if (a > maxv) a = maxv;
                s = sig_pos(a);
                if (xs < 0) s = one - s;
                sat = (a >= 5 * one);
                y = (mode == 2'b01) ? 2 * s - one : s;
            end
        endcase
        return {sat, y[DW-1:0]};
    endfunction

    function automatic beat_t model_beat(input logic [1:0] mode, input logic [W-1:0] data);
        beat_t       b;
        logic [DW:0] r;
        for (int k = 0; k < LN; k++) begin
            r = model_lane(mode, data[k*DW +: DW]);
            b.data[k*DW +: DW] = r[DW-1:0];
            b.sat[k] = r[DW];
        end
        return b;
    endfunction

    function automatic logic [DW-1:0] rand_val();
        logic [DW-1:0] edges [11];
        logic [DW-1:0] v;
        edges = '{32'h00050000, 32'h0004FFFF, 32'h00026000, 32'h00025FFF,
                  32'h00010000, 32'h0000FFFF, 32'hFFFB0000, 32'h80000000,
                  32'h7FFFFFFF, 32'h00028000, 32'hFFFDA000};
        case ($urandom_range(0, 3))
            0:       v = $urandom;
            1:       v = $urandom_range(0, 32'h00070000);
            2: begin v = $urandom_range(0, 32'h00070000); v = -v; end
            default: v = edges[$urandom_range(0, 10)];
        endcase
        return v;
    endfunction

    function automatic logic [W-1:0] rand_beat();
        logic [W-1:0] d;
        for (int k = 0; k < LN; k++) d[k*DW +: DW] = rand_val();
        return d;
    endfunction

    // ---------------- checking helpers ------------------------------------
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // One clock: check the current cycle's outputs, score transfers, advance.
    task automatic tick();
        beat_t e;
        chk("i_ready", W'(i_ready), W'(!o_valid || o_ready));
        if (prev_stall) begin
            chk("stall_valid", W'(o_valid), W'(1'b1));
            chk("stall_data", o_data, prev_data);
        end
        if (o_valid && o_ready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL extra_beat obs=%h exp=none", o_data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("beat_data", o_data, e.data);
                chk("beat_sat", W'(o_sat), W'(e.sat));
            end
        end
        if (i_valid && i_ready) exp_q.push_back(model_beat(i_mode, i_data));
        prev_stall = o_valid && !o_ready;
        prev_data  = o_data;
        @(posedge clk);
        #1;
    endtask

    task automatic send_check(input logic [1:0] mode, input logic [W-1:0] data,
                              input logic [W-1:0] exp_d, input logic [LN-1:0] exp_s,
                              input string tag);
        o_ready = 1'b1;
        i_valid = 1'b1;
        i_mode  = mode;
        i_data  = data;
        tick();
        i_valid = 1'b0;
        chk({tag, "_lat1"}, W'(o_valid), W'(1'b0));
        tick();
        chk({tag, "_lat2"}, W'(o_valid), W'(1'b0));
        tick();
        chk({tag, "_lat3"}, W'(o_valid), W'(1'b1));
        chk({tag, "_data"}, o_data, exp_d);
        chk({tag, "_sat"}, W'(o_sat), W'(exp_s));
        tick();
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 40 && exp_q.size() > 0; n++) tick();
        chk(tag, W'(exp_q.size()), W'(0));
    endtask

    // ---------------- stimulus --------------------------------------------
    initial begin
        logic [W-1:0] d;
        logic [3:0]   bp;
        logic         xfer;
        int           sent;
        beat_t        b;

        i_valid = 1'b0;
        i_mode  = 2'b00;
        i_data  = '0;
        o_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", W'(o_valid), W'(1'b0));
        chk("rst_o_data", o_data, '0);
        chk("rst_o_sat", W'(o_sat), W'(0));
        chk("rst_i_ready", W'(i_ready), W'(1'b1));
        rst_n = 1'b0;
        tick();

        // lanes listed 3..0
        send_check(2'b00, {32'h00060000, 32'hFFFF0000, 32'h00010000, 32'h00000000},
                   {32'h00010000, 32'h00004000, 32'h0000C000, 32'h00008000}, 4'b1000, "sig_basic");
        send_check(2'b00, {32'h7FFFFFFF, 32'h80000000, 32'hFFFDA000, 32'h00030000},
                   {32'h00010000, 32'h00000000, 32'h00001500, 32'h0000F000}, 4'b1100, "sig_edge");
        send_check(2'b01, {32'h40000000, 32'h00000000, 32'hFFFC0000, 32'h00008000},
                   {32'h00010000, 32'h00000000, 32'hFFFF0000, 32'h00008000}, 4'b1010, "tanh");
        send_check(2'b10, {32'h80000000, 32'h00000000, 32'h00028000, 32'hFFFD0000},
                   {32'h00000000, 32'h00000000, 32'h00028000, 32'h00000000}, 4'b0000, "relu");
        d = {$urandom, $urandom, $urandom, $urandom};
        send_check(2'b11, d, d, 4'b0000, "bypass");

        // mode changes every beat, full rate
        for (int i = 0; i < 24; i++) begin
            i_valid = 1'b1;
            i_mode  = 2'(i % 4);
            i_data  = rand_beat();
            tick();
        end
        i_valid = 1'b0;
        drain("alt_drain");

        // random beats under a 1,0,0,1 ready pattern
        bp      = 4'b1001;
        sent    = 0;
        i_valid = 1'b1;
        i_mode  = 2'($urandom_range(0, 3));
        i_data  = rand_beat();
        for (int c = 0; c < 80 && (sent < 8 || exp_q.size() > 0); c++) begin
            o_ready = bp[c % 4];
            #1;
            xfer = i_valid && i_ready;
            tick();
            if (xfer) begin
                sent++;
                if (sent < 8) begin
                    i_mode = 2'($urandom_range(0, 3));
                    i_data = rand_beat();
                end else begin
                    i_valid = 1'b0;
                end
            end
        end
        chk("bp_sent", W'(sent), W'(8));
        chk("bp_drained", W'(exp_q.size()), W'(0));
        o_ready = 1'b1;
        #1;
        tick();

        // reset with two beats in flight
        i_valid = 1'b1;
        i_mode  = 2'b00;
        i_data  = rand_beat();
        tick();
        i_data  = rand_beat();
        tick();
        i_valid = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        chk("midrst_valid", W'(o_valid), W'(1'b0));
        chk("midrst_data", o_data, '0);
        chk("midrst_sat", W'(o_sat), W'(0));
        exp_q.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("post_rst_idle", W'(o_valid), W'(1'b0));
        end
        d = rand_beat();
        b = model_beat(2'b01, d);
        send_check(2'b01, d, b.data, b.sat, "post_rst");

        drain("final_drain");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
